// File: rtl/vend_arbiter.sv
// vend_arbiter: shares one vending core between two customer coin ports.
//
// A requester is granted an exclusive session in round-robin order, and its
// coins are forwarded to the core. The core's drink/change pulses are routed
// back to the session owner one cycle after the core produces them. If the
// owner stalls, the controller forces a refund, or releases the session when
// no credit is held. Dispensed drinks are counted in a wrapping counter.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_valid[1:0]       requester i presents a coin
//   req_coin[3:0]        coin of requester i at [2i+1:2i]:
//                        00 none, 01 half, 10 one, 11 refund
//   req_ready[1:0]       coin of requester i accepted this cycle
//   grant[1:0]           one-hot session owner, 00 when idle
//   core_coin[1:0]       coin driven to the vending core
//   core_drink           core drink pulse, registered by the core
//   core_back[1:0]       core change, in half units
//   out_drink            drink pulse routed to the last owner
//   out_back[1:0]        change routed to the last owner
//   out_id               requester that out_drink/out_back belong to
//   busy                 session in progress (SERVE or WAIT)
//   sold_cnt[CNT_W-1:0]  drinks dispensed, wraps
module vend_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [3:0]       req_coin,
  output logic [1:0]       req_ready,
  output logic [1:0]       grant,
  output logic [1:0]       core_coin,
  input  logic             core_drink,
  input  logic [1:0]       core_back,
  output logic             out_drink,
  output logic [1:0]       out_back,
  output logic             out_id,
  output logic             busy,
  output logic [CNT_W-1:0] sold_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       credit_q, credit_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             last_q, last_d;
  logic             out_drink_q, out_drink_d;
  logic [1:0]       out_back_q, out_back_d;
  logic             out_id_q, out_id_d;
  logic [CNT_W-1:0] sold_q, sold_d;

  logic       owner;
  logic       own_valid;
  logic [1:0] own_coin;
  logic       pick;
  logic       timed_out;
  logic       xfer;
  logic [2:0] sum;
  logic       ending;

  assign owner     = grant_q[1];
  assign own_valid = req_valid[owner];
  assign own_coin  = owner ? req_coin[3:2] : req_coin[1:0];
  // Lone requester wins; on contention the one that did not own last goes.
  assign pick      = (&req_valid) ? ~last_q : req_valid[1];
  // Timeout pre-empts any coin the owner presents in the same cycle.
  assign timed_out = (state_q == ST_SERVE) && (timer_q == TW'(TIMEOUT - 1));
  assign xfer      = (state_q == ST_SERVE) && !timed_out && own_valid && (own_coin != 2'b00);
  assign sum       = {1'b0, credit_q} + {1'b0, own_coin};
  assign ending    = xfer && ((own_coin == 2'b11) || (sum >= 3'd3));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    credit_d    = credit_q;
    timer_d     = timer_q;
    last_d      = last_q;
    out_drink_d = 1'b0;
    out_back_d  = 2'b00;
    out_id_d    = out_id_q;
    sold_d      = sold_q;
    req_ready   = 2'b00;
    core_coin   = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d  = pick ? 2'b10 : 2'b01;
          state_d  = ST_SERVE;
          credit_d = 2'b00;
          timer_d  = '0;
        end
      end
      ST_SERVE: begin
        if (timed_out) begin
          if (credit_q != 2'b00) begin
            // Refund the stalled owner's partial credit through the core.
            core_coin = 2'b11;
            state_d   = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
            last_d  = owner;
            grant_d = 2'b00;
          end
        end else begin
          req_ready = owner ? 2'b10 : 2'b01;
          if (xfer) begin
            core_coin = own_coin;
            if (ending) begin
              state_d = ST_WAIT;
            end else begin
              credit_d = sum[1:0];
              timer_d  = '0;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      ST_WAIT: begin
        // The core's registered response to the ending coin lands here.
        out_drink_d = core_drink;
        out_back_d  = core_back;
        out_id_d    = owner;
        sold_d      = sold_q + CNT_W'(core_drink);
        state_d     = ST_IDLE;
        last_d      = owner;
        grant_d     = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      credit_q    <= 2'b00;
      timer_q     <= '0;
      last_q      <= 1'b1;
      out_drink_q <= 1'b0;
      out_back_q  <= 2'b00;
      out_id_q    <= 1'b0;
      sold_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      credit_q    <= credit_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      out_drink_q <= out_drink_d;
      out_back_q  <= out_back_d;
      out_id_q    <= out_id_d;
      sold_q      <= sold_d;
    end
  end

  assign grant     = grant_q;
  assign out_drink = out_drink_q;
  assign out_back  = out_back_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != ST_IDLE);
  assign sold_cnt  = sold_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed bench for vend_arbiter with a small behavioural vending core.
module tb_vend_arbiter;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [3:0]       req_coin;
  logic [1:0]       req_ready;
  logic [1:0]       grant;
  logic [1:0]       core_coin;
  logic             core_drink;
  logic [1:0]       core_back;
  logic             out_drink;
  logic [1:0]       out_back;
  logic             out_id;
  logic             busy;
  logic [CNT_W-1:0] sold_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vend_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_coin   (req_coin),
    .req_ready  (req_ready),
    .grant      (grant),
    .core_coin  (core_coin),
    .core_drink (core_drink),
    .core_back  (core_back),
    .out_drink  (out_drink),
    .out_back   (out_back),
    .out_id     (out_id),
    .busy       (busy),
    .sold_cnt   (sold_cnt)
  );

  // Vending core: price 3 half units, registered drink/change, 11 refunds.
  logic [2:0] core_credit;
  logic [2:0] core_sum;
  assign core_sum = core_credit + {1'b0, core_coin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_credit <= 3'd0;
      core_drink  <= 1'b0;
      core_back   <= 2'b00;
    end else begin
      core_drink <= 1'b0;
      core_back  <= 2'b00;
      if (core_coin == 2'b11) begin
        core_back   <= core_credit[1:0];
        core_credit <= 3'd0;
      end else if (core_coin != 2'b00) begin
        if (core_sum >= 3'd3) begin
          core_drink  <= 1'b1;
          core_back   <= 2'(core_sum - 3'd3);
          core_credit <= 3'd0;
        end else begin
          core_credit <= core_sum;
        end
      end
    end
  end

  // Apply inputs just after the falling edge; outputs are then stable for sampling.
  task automatic drive(input logic [1:0] v, input logic [3:0] c);
    @(negedge clk);
    req_valid = v;
    req_coin  = c;
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    req_coin  = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({grant, req_ready, core_coin} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000000", {grant, req_ready, core_coin});
    end
    checks++;
    if ({out_drink, out_back, out_id, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_out got=%b exp=00000", {out_drink, out_back, out_id, busy});
    end
    checks++;
    if (sold_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_sold got=%0d exp=0", sold_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_req0_halves();
    drive(2'b01, 4'b0001);
    checks++;
    if ({req_ready, busy} !== 3'b000) begin
      failures++; $display("FAIL halves_idle got=%b exp=000", {req_ready, busy});
    end
    drive(2'b01, 4'b0001);
    checks++;
    if ({grant, req_ready, core_coin} !== 6'b010101) begin
      failures++;
      $display("FAIL halves_c1 got=%b exp=010101", {grant, req_ready, core_coin});
    end
    drive(2'b01, 4'b0001);
    checks++;
    if (core_coin !== 2'b01) begin
      failures++; $display("FAIL halves_c2 got=%b exp=01", core_coin);
    end
    drive(2'b01, 4'b0001);
    checks++;
    if (core_coin !== 2'b01) begin
      failures++; $display("FAIL halves_c3 got=%b exp=01", core_coin);
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({busy, req_ready, core_coin} !== 5'b10000) begin
      failures++;
      $display("FAIL halves_wait got=%b exp=10000", {busy, req_ready, core_coin});
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({out_drink, out_back, out_id, grant, busy} !== 7'b1000000) begin
      failures++;
      $display("FAIL halves_out got=%b exp=1000000", {out_drink, out_back, out_id, grant, busy});
    end
    checks++;
    if (sold_cnt !== 8'd1) begin
      failures++; $display("FAIL halves_sold got=%0d exp=1", sold_cnt);
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({out_drink, out_back} !== 3'b000) begin
      failures++; $display("FAIL halves_pulse got=%b exp=000", {out_drink, out_back});
    end
  endtask

  task automatic test_req0_ones();
    drive(2'b01, 4'b0010);
    drive(2'b01, 4'b0010);
    checks++;
    if (core_coin !== 2'b10) begin
      failures++; $display("FAIL ones_c1 got=%b exp=10", core_coin);
    end
    drive(2'b01, 4'b0010);
    checks++;
    if ({core_coin, req_ready} !== 4'b1001) begin
      failures++; $display("FAIL ones_c2 got=%b exp=1001", {core_coin, req_ready});
    end
    drive(2'b00, 4'b0000);
    drive(2'b00, 4'b0000);
    checks++;
    if ({out_drink, out_back, out_id} !== 4'b1010) begin
      failures++; $display("FAIL ones_out got=%b exp=1010", {out_drink, out_back, out_id});
    end
    checks++;
    if (sold_cnt !== 8'd2) begin
      failures++; $display("FAIL ones_sold got=%0d exp=2", sold_cnt);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive(2'b11, 4'b0101);
    checks++;
    if (req_ready !== 2'b00) begin
      failures++; $display("FAIL cont_idle got=%b exp=00", req_ready);
    end
    drive(2'b11, 4'b0110);
    checks++;
    if ({grant, req_ready, core_coin} !== 6'b010110) begin
      failures++;
      $display("FAIL cont_g0 got=%b exp=010110", {grant, req_ready, core_coin});
    end
    drive(2'b11, 4'b0110);
    checks++;
    if ({req_ready, core_coin} !== 4'b0110) begin
      failures++; $display("FAIL cont_end0 got=%b exp=0110", {req_ready, core_coin});
    end
    drive(2'b10, 4'b0100);
    checks++;
    if ({req_ready, core_coin} !== 4'b0000) begin
      failures++; $display("FAIL cont_wait got=%b exp=0000", {req_ready, core_coin});
    end
    drive(2'b10, 4'b0100);
    checks++;
    if ({req_ready, grant, out_drink, out_back, out_id} !== 8'b00001010) begin
      failures++;
      $display("FAIL cont_out0 got=%b exp=00001010",
               {req_ready, grant, out_drink, out_back, out_id});
    end
    drive(2'b10, 4'b0100);
    checks++;
    if ({grant, req_ready, core_coin} !== 6'b101001) begin
      failures++;
      $display("FAIL cont_g1 got=%b exp=101001", {grant, req_ready, core_coin});
    end
    drive(2'b10, 4'b1000);
    checks++;
    if (core_coin !== 2'b10) begin
      failures++; $display("FAIL cont_end1 got=%b exp=10", core_coin);
    end
    drive(2'b00, 4'b0000);
    drive(2'b00, 4'b0000);
    checks++;
    if ({out_drink, out_back, out_id} !== 4'b1001) begin
      failures++; $display("FAIL cont_out1 got=%b exp=1001", {out_drink, out_back, out_id});
    end
    checks++;
    if (sold_cnt !== 8'd2) begin
      failures++; $display("FAIL cont_sold got=%0d exp=2", sold_cnt);
    end
  endtask

  task automatic test_timeout_refund();
    drive(2'b10, 4'b0100);
    drive(2'b10, 4'b0100);
    checks++;
    if ({grant, core_coin} !== 4'b1001) begin
      failures++; $display("FAIL tmo_coin got=%b exp=1001", {grant, core_coin});
    end
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(2'b00, 4'b0000);
      checks++;
      if ({busy, core_coin, req_ready} !== 5'b10010) begin
        failures++;
        $display("FAIL tmo_stall%0d got=%b exp=10010", i, {busy, core_coin, req_ready});
      end
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({core_coin, req_ready} !== 4'b1100) begin
      failures++; $display("FAIL tmo_force got=%b exp=1100", {core_coin, req_ready});
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({busy, core_coin} !== 3'b100) begin
      failures++; $display("FAIL tmo_wait got=%b exp=100", {busy, core_coin});
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({out_drink, out_back, out_id} !== 4'b0011) begin
      failures++; $display("FAIL tmo_out got=%b exp=0011", {out_drink, out_back, out_id});
    end
    checks++;
    if (sold_cnt !== 8'd2) begin
      failures++; $display("FAIL tmo_sold got=%0d exp=2", sold_cnt);
    end
  endtask

  task automatic test_idle_release();
    drive(2'b01, 4'b0000);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(2'b01, 4'b0000);
      checks++;
      if ({busy, grant, req_ready, core_coin} !== 7'b1010100) begin
        failures++;
        $display("FAIL rel_hold%0d got=%b exp=1010100", i, {busy, grant, req_ready, core_coin});
      end
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({busy, req_ready, core_coin} !== 5'b10000) begin
      failures++; $display("FAIL rel_last got=%b exp=10000", {busy, req_ready, core_coin});
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({busy, grant, out_drink, out_back} !== 6'b000000) begin
      failures++;
      $display("FAIL rel_idle got=%b exp=000000", {busy, grant, out_drink, out_back});
    end
    // last is now 0, so a lone req1 refund with zero credit.
    drive(2'b10, 4'b1100);
    drive(2'b10, 4'b1100);
    checks++;
    if ({grant, core_coin} !== 4'b1011) begin
      failures++; $display("FAIL ref0_coin got=%b exp=1011", {grant, core_coin});
    end
    drive(2'b00, 4'b0000);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL ref0_wait got=%b exp=1", busy);
    end
    drive(2'b00, 4'b0000);
    checks++;
    if ({out_drink, out_back, out_id, busy} !== 5'b00010) begin
      failures++;
      $display("FAIL ref0_out got=%b exp=00010", {out_drink, out_back, out_id, busy});
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b01, 4'b0010);
    drive(2'b01, 4'b0010);
    drive(2'b00, 4'b0000);
    checks++;
    if ({busy, grant, sold_cnt} !== {3'b101, 8'd2}) begin
      failures++; $display("FAIL rst_pre got=%b/%0d exp=101/2", {busy, grant}, sold_cnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, grant, req_ready, core_coin, out_drink, out_back, out_id} !== 11'b0) begin
      failures++;
      $display("FAIL rst_mid got=%b exp=0", {busy, grant, req_ready, core_coin,
                                             out_drink, out_back, out_id});
    end
    checks++;
    if (sold_cnt !== 8'd0) begin
      failures++; $display("FAIL rst_sold got=%0d exp=0", sold_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, 4'b0101);
    drive(2'b11, 4'b0101);
    checks++;
    if ({grant, core_coin, out_drink, out_back} !== 7'b0101000) begin
      failures++;
      $display("FAIL rst_rearb got=%b exp=0101000", {grant, core_coin, out_drink, out_back});
    end
    drive(2'b00, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_req0_halves();
    test_req0_ones();
    test_contention();
    test_timeout_refund();
    test_idle_release();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_arbiter.md
Name: vend_arbiter

Overview:
- Shares one vending core (coin[1:0] in; drink, back[1:0] out) between two customer coin ports.
- Grants exclusive sessions in round-robin order and forwards the owner's coins to the core.
- Routes the core's drink/change pulses back to the owner.
- Forces a refund when an owner stalls mid-purchase, and counts drinks sold.

Parameters:
- TIMEOUT, 16, idle cycles in SERVE before the controller intervenes (>=2)
- CNT_W, 8, width of sold_cnt

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- req_valid  input  2  bit i: requester i presents a coin
- req_coin  input  4  [2i+1:2i] coin of requester i: 00 none, 01 half, 10 one, 11 refund
- req_ready  output  2  bit i: coin of requester i accepted this cycle
- grant  output  2  one-hot session owner; 00 when idle
- core_coin  output  2  coin driven to the vending core
- core_drink  input  1  core drink pulse, registered by the core
- core_back  input  2  core change, half units
- out_drink  output  1  drink pulse routed to the last owner
- out_back  output  2  change routed to the last owner
- out_id  output  1  requester index that out_drink/out_back belong to
- busy  output  1  state != IDLE
- sold_cnt  output  CNT_W  drinks dispensed, wraps

Behaviour:
- Reset values: grant=00, req_ready=00, core_coin=00, out_drink=0, out_back=00, out_id=0, busy=0, sold_cnt=0, credit=0, timer=0, last=1, state=IDLE. The core shares this reset.
- Credit mirror: 2-bit, half-yuan units. 01 adds 1, 10 adds 2. Price is 3.
- States: IDLE, SERVE, WAIT.
- IDLE arbitration:
  - If any req_valid bit is set, grant requester g and go to SERVE (registered, visible next cycle). Set credit=0 and timer=0.
  - g = the only valid requester; if both are valid, g = the requester other than last.
  - No coin is accepted in IDLE.
- SERVE forwarding:
  - req_ready[g]=1, combinational; req_ready of the other requester is 0.
  - Transfer = req_valid[g] && req_coin[g] != 00. During a transfer, core_coin = req_coin[g]; otherwise core_coin = 00.
  - valid with coin 00 is a no-op and does not reset the timer.
- Ending transfer: coin 11, or credit + coin value >= 3. Go to WAIT.
- Non-ending transfer: update credit, timer=0, stay in SERVE.
- Timeout:
  - timer increments on each non-transfer SERVE cycle.
  - When timer reaches TIMEOUT-1 with credit > 0: drive core_coin=11 on that cycle, set req_ready=0, go to WAIT.
  - When timer reaches TIMEOUT-1 with credit = 0: go to IDLE, last=g, no outputs.
- WAIT (exactly one cycle, i.e. the cycle after the ending coin):
  - core_coin=00, req_ready=00.
  - Register out_drink=core_drink, out_back=core_back, out_id=g.
  - sold_cnt += core_drink, wrapping from 2^CNT_W-1 to 0.
  - Next state IDLE, last=g, grant=00.
- Output pulse timing: out_drink/out_back are visible one cycle only, in the cycle after WAIT. They return to 0 in the following cycle.
- Latency: coin at cycle t; core responds at t+1; routed outputs at t+2. A new grant is visible at t+3 at the earliest.
- Core outputs arriving outside WAIT are ignored.
- Refund with credit 0 (ending coin 11) still passes through WAIT and yields out_back=00.
- Asynchronous reset mid-session discards credit; no refund pulse is produced. This is legal because the core clears too.
- grant is always one-hot or zero. busy=1 in SERVE and WAIT.

Test Plan:
- Req0 only: coins 01, 01, 01 on consecutive SERVE cycles. Expect core_coin follows the coins, WAIT, then out_drink=1, out_back=00, out_id=0 for one cycle; sold_cnt=1; grant back to 00.
- Req0 coins 10, 10. The second coin ends the session. Expect out_drink=1, out_back=01, out_id=0.
- Both valid after reset (last=1): grant=01 first. Req1 is held with req_ready[1]=0 until req0's session ends, then grant=10. Req1 buys 01, 10 → out_id=1, out_drink=1, out_back=00.
- Req1 owns, inserts 01, then stays idle for TIMEOUT=16 cycles. Expect controller core_coin=11 in the timeout cycle, then out_back=01, out_drink=0, out_id=1, sold_cnt unchanged.
- Granted with credit 0 and no coins: released to IDLE after TIMEOUT cycles with no output pulse. Also: owner sends 11 with credit 0 → out_back=00.
- Assert reset during SERVE with credit 2: all outputs return to reset values immediately. sold_cnt=0. Next arbitration favours req0.
